jpeg_bit_packer: RTL and testbench

Consumer end of the entropy encoder's variable-length code interface: accepts right-aligned codes (`in_code`/`in_len`) and packs them MSB-first into a JPEG byte stream. The output is byte-wide with ready/valid backpressure. The packer inserts a 0x00 stuff byte after every 0xFF data byte. On flush it pads the final partial byte with 1s and signals completion. It sits between `bamodule` and the byte sink (FIFO or bus writer).

---
 rtl/jpeg_bit_packer.sv | 67 ++++++
 tb/tb_jpeg_bit_packer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs right-aligned VLC codes MSB-first into a byte stream with 0xFF/0x00 stuffing and 1s-padded flush
module jpeg_bit_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_code,
  input  logic [3:0]  in_len,
  output logic        in_ready,
  input  logic        flush,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        flush_done
);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, acc_s;
  logic [4:0]  bit_cnt_q, bit_cnt_d, cnt_s;
  logic        stuff_q, stuff_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        flush_done_q, flush_done_d;
  logic        free, take, load_stuff, load_byte, pad;
  logic [15:0] code_m;
  assign in_ready   = state_q == RUN && bit_cnt_q <= 5'd16;
  assign free       = !byte_valid_q || byte_ready;
  assign take       = in_valid && in_ready;
  assign load_stuff = free && stuff_q;
  assign load_byte  = free && !stuff_q && bit_cnt_q >= 5'd8;
  assign pad        = state_q == FLUSH && !stuff_q && bit_cnt_q != 5'd0 && bit_cnt_q < 5'd8;
  assign code_m     = in_code & ((16'd1 << in_len) - 16'd1);
  always_comb begin
    acc_s        = load_byte ? {acc_q[23:0], 8'h00} : acc_q;
    cnt_s        = load_byte ? bit_cnt_q - 5'd8 : bit_cnt_q;
    acc_d        = take ? acc_s | (({code_m, 16'h0000} << (5'd16 - {1'b0, in_len})) >> cnt_s)
                 : pad ? acc_s | ((32'hFF00_0000 >> cnt_s) & 32'hFF00_0000) : acc_s;
    bit_cnt_d    = take ? cnt_s + {1'b0, in_len} : pad ? 5'd8 : cnt_s;
    stuff_d      = load_stuff ? 1'b0 : (load_byte && acc_q[31:24] == 8'hFF) ? 1'b1 : stuff_q;
    byte_valid_d = free ? (load_stuff || load_byte) : byte_valid_q;
    byte_data_d  = load_stuff ? 8'h00 : load_byte ? acc_q[31:24] : byte_data_q;
    state_d      = state_q == RUN ? (flush ? FLUSH : RUN)
                 : state_q == FLUSH ? ((bit_cnt_q == 5'd0 && !stuff_q && free) ? DONE : FLUSH) : RUN;
    flush_done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      stuff_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      stuff_q      <= stuff_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      flush_done_q <= flush_done_d;
    end
  end
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign flush_done = flush_done_q;
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: directed self-checking bench for jpeg_bit_packer
module tb_jpeg_bit_packer;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, byte_valid, byte_ready, flush_done;
  logic [15:0] in_code;
  logic [3:0]  in_len;
  logic [7:0]  byte_data;
  logic [7:0]  got_q[$], exp_q[$];
  int          n_chk = 0, n_fail = 0;
  jpeg_bit_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_len(in_len),
    .in_ready(in_ready), .flush(flush), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .flush_done(flush_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && byte_valid && byte_ready) got_q.push_back(byte_data);
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] code, input logic [3:0] len);
    in_valid = 1'b1;
    in_code  = code;
    in_len   = len;
    step();
    in_valid = 1'b0;
    in_code  = '0;
    in_len   = '0;
  endtask
  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0; flush = 1'b0; byte_ready = 1'b0;
    repeat (2) step();
    check("rst_bv", byte_valid, 0);
    check("rst_bd", byte_data, 8'h00);
    check("rst_fd", flush_done, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    byte_ready = 1'b1;
    send(16'b101, 4'd3);
    send(16'b11111, 4'd5);
    check("pack_not_yet", byte_valid, 0);
    step();
    check("pack_bv", byte_valid, 1);
    check("pack_bd", byte_data, 8'hBF);
    step();
    check("pack_cnt", dut.bit_cnt_q, 0);
    check("pack_idle", byte_valid, 0);
    exp_q = {8'hBF};
    check_stream("pack");
    send(16'hFFFF, 4'd0);
    check("len0_cnt", dut.bit_cnt_q, 0);
    send(16'hFFF0, 4'd4);
    send(16'h000F, 4'd4);
    repeat (2) step();
    exp_q = {8'h0F};
    check_stream("mask");
    send(16'h00FF, 4'd8);
    step();
    check("stuff1_ff", byte_data, 8'hFF);
    step();
    check("stuff1_00_bv", byte_valid, 1);
    check("stuff1_00", byte_data, 8'h00);
    step();
    exp_q = {8'hFF, 8'h00};
    check_stream("stuff1");
    send(16'hFFFF, 4'd15);
    send(16'h0001, 4'd1);
    check("stuff2_first", byte_data, 8'hFF);
    step();
    check("stuff2_nogap", byte_data, 8'h00);
    repeat (4) step();
    exp_q = {8'hFF, 8'h00, 8'hFF, 8'h00};
    check_stream("stuff2");
    send(16'b010, 4'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_rdy0", in_ready, 0);
    step();
    check("fl_rdy_pad", in_ready, 0);
    step();
    check("fl_bv", byte_valid, 1);
    check("fl_bd", byte_data, 8'h5F);
    check("fl_fd_early", flush_done, 0);
    step();
    check("fl_fd", flush_done, 1);
    check("fl_rdy_done", in_ready, 0);
    step();
    check("fl_fd_pulse", flush_done, 0);
    check("fl_rdy1", in_ready, 1);
    exp_q = {8'h5F};
    check_stream("flush");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("idle_fd0", flush_done, 0);
    step();
    check("idle_fd1", flush_done, 1);
    step();
    byte_ready = 1'b0;
    send(16'h7FFF, 4'd15);
    send(16'h7FFF, 4'd15);
    check("bp_cnt", dut.bit_cnt_q, 22);
    check("bp_rdy", in_ready, 0);
    check("bp_bd", byte_data, 8'hFF);
    repeat (3) step();
    check("bp_hold_bv", byte_valid, 1);
    check("bp_hold_bd", byte_data, 8'hFF);
    byte_ready = 1'b1;
    repeat (6) step();
    exp_q = {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    check_stream("bp");
    check("bp_cnt_left", dut.bit_cnt_q, 6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    begin
      int n = 0;
      while (!flush_done && n < 30) begin
        step();
        n++;
      end
    end
    check("bp_flush_done", flush_done, 1);
    exp_q = {8'hFF, 8'h00};
    check_stream("bp_tail");
    step();
    byte_ready = 1'b0;
    send(16'hFFFF, 4'd15);
    send(16'h001F, 4'd5);
    check("mr_cnt", dut.bit_cnt_q, 12);
    check("mr_bd", byte_data, 8'hFF);
    check("mr_stuff", dut.stuff_q, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_bv", byte_valid, 0);
    check("mr_bd0", byte_data, 8'h00);
    check("mr_fd", flush_done, 0);
    check("mr_cnt0", dut.bit_cnt_q, 0);
    step();
    rst_n = 1'b1;
    byte_ready = 1'b1;
    repeat (5) step();
    check("mr_no_bytes", got_q.size(), 0);
    check("mr_idle", byte_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
